// File: rtl/pos_pkg.sv
// Shared constants and types for the X/Y position tracker.
package pos_pkg;

    localparam int DIR_RIGHT = 3;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_UP    = 0;

    localparam int EDGE_X_MAX = 3;
    localparam int EDGE_X_MIN = 2;
    localparam int EDGE_Y_MIN = 1;
    localparam int EDGE_Y_MAX = 0;

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rpt_state_e;

    // Opposing buttons cancel each other out.
    function automatic logic signed [1:0] axis_dir(input logic plus, input logic minus);
        if (plus && !minus) begin
            return 2'sd1;
        end else if (minus && !plus) begin
            return -2'sd1;
        end
        return 2'sd0;
    endfunction

endpackage

// File: rtl/pos_axis.sv
// One coordinate axis: load clipping, then wrap or clamp stepping within 0..MAX.
module pos_axis #(
    parameter int WIDTH  = 8,
    parameter int MAX    = 255,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  pos_i,
    input  logic signed [1:0] dir_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              wrap_en_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    output logic [WIDTH-1:0]  next_o,
    output logic              changed_o
);

    localparam logic [WIDTH:0] MAX_E  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] MAX_P1 = (WIDTH+1)'(MAX + 1);

    logic [WIDTH:0] pos_e;
    logic [WIDTH:0] step_e;
    logic [WIDTH:0] load_e;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] res;

    assign pos_e  = {1'b0, pos_i};
    assign step_e = (WIDTH+1)'(step_i);
    assign load_e = {1'b0, load_val_i};
    assign sum    = pos_e + step_e;

    always_comb begin
        res = pos_e;
        if (load_i) begin
            res = (load_e > MAX_E) ? MAX_E : load_e;
        end else if (dir_i > 2'sd0) begin
            if (sum > MAX_E) begin
                res = wrap_en_i ? (sum - MAX_P1) : MAX_E;
            end else begin
                res = sum;
            end
        end else if (dir_i < 2'sd0) begin
            // pos + (MAX+1) stays below 2^(WIDTH+1), so no intermediate overflow.
            if (step_e > pos_e) begin
                res = wrap_en_i ? (pos_e + MAX_P1 - step_e) : '0;
            end else begin
                res = pos_e - step_e;
            end
        end
    end

    assign next_o    = WIDTH'(res);
    assign changed_o = (next_o != pos_i);

endmodule

// File: rtl/pos_tracker.sv
// X/Y cursor position tracker with wrap/clamp edges and load.
// Define POS_TRACKER_AUTOREPEAT_EN to build the held-button auto-repeat timer.
module pos_tracker
    import pos_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int X_MAX        = 255,
    parameter int Y_MAX        = 255,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 0,
    parameter int STEP_W       = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        dir_rldu,
    input  logic [STEP_W-1:0] step,
    input  logic              wrap_en,
    input  logic              load_valid,
    input  logic [WIDTH-1:0]  load_x,
    input  logic [WIDTH-1:0]  load_y,
    output logic [WIDTH-1:0]  x_pos,
    output logic [WIDTH-1:0]  y_pos,
    output logic              moved,
    output logic [3:0]        at_edge
);

    logic signed [1:0] dx;
    logic signed [1:0] dy;
    logic signed [1:0] dx_mv;
    logic signed [1:0] dy_mv;
    logic              dir_nz;
    logic              tick;

    assign dx     = axis_dir(dir_rldu[DIR_RIGHT], dir_rldu[DIR_LEFT]);
    assign dy     = axis_dir(dir_rldu[DIR_UP], dir_rldu[DIR_DOWN]);
    assign dir_nz = (dx != 2'sd0) || (dy != 2'sd0);

`ifdef POS_TRACKER_AUTOREPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    rpt_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       dir_q;
    logic             new_press;
    logic             delay_done;
    logic             rate_done;

    assign new_press  = ({dx, dy} != dir_q);
    assign delay_done = (cnt_q == CNT_W'(REPEAT_DELAY - 1));
    assign rate_done  = (cnt_q == CNT_W'(REPEAT_RATE - 1));

    always_comb begin
        tick = 1'b0;
        if (!load_valid && dir_nz) begin
            unique case (state_q)
                IDLE:    tick = 1'b1;
                DELAY:   tick = new_press || delay_done;
                REPEAT:  tick = new_press || rate_done;
                default: tick = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= '0;
        end else begin
            dir_q <= {dx, dy};
            if (load_valid || !dir_nz) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (state_q == IDLE || new_press) begin
                state_q <= DELAY;
                cnt_q   <= '0;
            end else if (state_q == DELAY) begin
                if (delay_done) begin
                    state_q <= REPEAT;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= rate_done ? '0 : cnt_q + 1'b1;
            end
        end
    end
`else
    assign tick = dir_nz;
`endif

    assign dx_mv = tick ? dx : 2'sd0;
    assign dy_mv = tick ? dy : 2'sd0;

    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             moved_q;
    logic             x_chg, y_chg;

    pos_axis #(.WIDTH(WIDTH), .MAX(X_MAX), .STEP_W(STEP_W)) u_axis_x (
        .pos_i      (x_q),
        .dir_i      (dx_mv),
        .step_i     (step),
        .wrap_en_i  (wrap_en),
        .load_i     (load_valid),
        .load_val_i (load_x),
        .next_o     (x_d),
        .changed_o  (x_chg)
    );

    pos_axis #(.WIDTH(WIDTH), .MAX(Y_MAX), .STEP_W(STEP_W)) u_axis_y (
        .pos_i      (y_q),
        .dir_i      (dy_mv),
        .step_i     (step),
        .wrap_en_i  (wrap_en),
        .load_i     (load_valid),
        .load_val_i (load_y),
        .next_o     (y_d),
        .changed_o  (y_chg)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q     <= WIDTH'(X_INIT);
            y_q     <= WIDTH'(Y_INIT);
            moved_q <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            moved_q <= x_chg || y_chg;
        end
    end

    assign x_pos = x_q;
    assign y_pos = y_q;
    assign moved = moved_q;

    always_comb begin
        at_edge             = '0;
        at_edge[EDGE_X_MAX] = (x_q == WIDTH'(X_MAX));
        at_edge[EDGE_X_MIN] = (x_q == '0);
        at_edge[EDGE_Y_MIN] = (y_q == '0);
        at_edge[EDGE_Y_MAX] = (y_q == WIDTH'(Y_MAX));
    end

endmodule

// File: tb/tb_pos_tracker.sv
// Directed bench for pos_tracker on a 160x120 grid; honours POS_TRACKER_AUTOREPEAT_EN.
module tb_pos_tracker;

    localparam int RD = 16;
    localparam int RR = 4;

    logic       clk;
    logic       rst;
    logic [3:0] dir_rldu;
    logic [3:0] step;
    logic       wrap_en;
    logic       load_valid;
    logic [7:0] load_x;
    logic [7:0] load_y;
    logic [7:0] x_pos;
    logic [7:0] y_pos;
    logic       moved;
    logic [3:0] at_edge;

    int checks = 0;
    int errors = 0;

    pos_tracker #(
        .WIDTH(8), .X_MAX(159), .Y_MAX(119), .X_INIT(10), .Y_INIT(20),
        .STEP_W(4), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut (
        .clk(clk), .rst(rst), .dir_rldu(dir_rldu), .step(step), .wrap_en(wrap_en),
        .load_valid(load_valid), .load_x(load_x), .load_y(load_y),
        .x_pos(x_pos), .y_pos(y_pos), .moved(moved), .at_edge(at_edge)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dir;
        logic [3:0] stp;
        logic       wrap;
        logic       ld;
        logic [7:0] lx;
        logic [7:0] ly;
        logic [7:0] ex;
        logic [7:0] ey;
        logic       em;
        logic [3:0] ee;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic [3:0] s, input logic w,
                         input logic ld, input logic [7:0] lx, input logic [7:0] ly);
        dir_rldu   = d;
        step       = s;
        wrap_en    = w;
        load_valid = ld;
        load_x     = lx;
        load_y     = ly;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Expected tick on the k-th cycle of a continuous hold (k=0 is the press).
    function automatic logic exp_move(input int k);
`ifdef POS_TRACKER_AUTOREPEAT_EN
        return (k == 0) || (k == RD) || (k > RD && ((k - RD) % RR) == 0);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] inc_wrap(input logic [7:0] v, input logic [7:0] mx);
        return (v == mx) ? 8'd0 : v + 8'd1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] xe;
        logic [7:0] ye;
        logic       m;

        //              dir      stp  wrap  ld  lx   ly    ex   ey   em  ee
        tbl[0]  = '{4'b0000, 4'd0,  1'b0, 1'b1, 8'd158, 8'd0,   8'd158, 8'd0,   1'b1, 4'b0010};
        tbl[1]  = '{4'b1000, 4'd3,  1'b1, 1'b0, 8'd0,   8'd0,   8'd1,   8'd0,   1'b1, 4'b0010};
        tbl[2]  = '{4'b0010, 4'd1,  1'b1, 1'b0, 8'd0,   8'd0,   8'd1,   8'd119, 1'b1, 4'b0001};
        tbl[3]  = '{4'b0000, 4'd0,  1'b0, 1'b1, 8'd158, 8'd119, 8'd158, 8'd119, 1'b1, 4'b0001};
        tbl[4]  = '{4'b1000, 4'd3,  1'b0, 1'b0, 8'd0,   8'd0,   8'd159, 8'd119, 1'b1, 4'b1001};
        tbl[5]  = '{4'b1000, 4'd3,  1'b0, 1'b0, 8'd0,   8'd0,   8'd159, 8'd119, 1'b0, 4'b1001};
        tbl[6]  = '{4'b0001, 4'd2,  1'b0, 1'b0, 8'd0,   8'd0,   8'd159, 8'd119, 1'b0, 4'b1001};
        tbl[7]  = '{4'b1100, 4'd1,  1'b0, 1'b0, 8'd0,   8'd0,   8'd159, 8'd119, 1'b0, 4'b1001};
        tbl[8]  = '{4'b0110, 4'd5,  1'b0, 1'b0, 8'd0,   8'd0,   8'd154, 8'd114, 1'b1, 4'b0000};
        tbl[9]  = '{4'b1001, 4'd1,  1'b0, 1'b0, 8'd0,   8'd0,   8'd155, 8'd115, 1'b1, 4'b0000};
        tbl[10] = '{4'b1000, 4'd0,  1'b0, 1'b0, 8'd0,   8'd0,   8'd155, 8'd115, 1'b0, 4'b0000};
        tbl[11] = '{4'b0000, 4'd0,  1'b0, 1'b1, 8'd200, 8'd50,  8'd159, 8'd50,  1'b1, 4'b1000};
        tbl[12] = '{4'b0000, 4'd0,  1'b0, 1'b1, 8'd159, 8'd50,  8'd159, 8'd50,  1'b0, 4'b1000};
        tbl[13] = '{4'b1001, 4'd1,  1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   8'd51,  1'b1, 4'b0100};
        tbl[14] = '{4'b0100, 4'd4,  1'b0, 1'b0, 8'd0,   8'd0,   8'd0,   8'd51,  1'b0, 4'b0100};
        tbl[15] = '{4'b0100, 4'd4,  1'b1, 1'b0, 8'd0,   8'd0,   8'd156, 8'd51,  1'b1, 4'b0000};
        tbl[16] = '{4'b0000, 4'd0,  1'b0, 1'b1, 8'd0,   8'd0,   8'd0,   8'd0,   1'b1, 4'b0110};
        tbl[17] = '{4'b0010, 4'd15, 1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   8'd105, 1'b1, 4'b0100};
        tbl[18] = '{4'b0011, 4'd1,  1'b1, 1'b0, 8'd0,   8'd0,   8'd0,   8'd105, 1'b0, 4'b0100};

        clk = 1'b0;
        rst = 1'b1;
        drive(4'b0000, 4'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        #12;
        chk("reset_x", 32'(x_pos), 32'd10);
        chk("reset_y", 32'(y_pos), 32'd20);
        chk("reset_moved", 32'(moved), 32'd0);
        chk("reset_edge", 32'(at_edge), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("idle_x", 32'(x_pos), 32'd10);

        // Each vector is a fresh press, followed by a release cycle.
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].dir, tbl[i].stp, tbl[i].wrap, tbl[i].ld, tbl[i].lx, tbl[i].ly);
            cycle();
            chk($sformatf("vec%0d_x", i), 32'(x_pos), 32'(tbl[i].ex));
            chk($sformatf("vec%0d_y", i), 32'(y_pos), 32'(tbl[i].ey));
            chk($sformatf("vec%0d_moved", i), 32'(moved), 32'(tbl[i].em));
            chk($sformatf("vec%0d_edge", i), 32'(at_edge), 32'(tbl[i].ee));
            drive(4'b0000, tbl[i].stp, tbl[i].wrap, 1'b0, 8'd0, 8'd0);
            cycle();
            chk($sformatf("vec%0d_release_moved", i), 32'(moved), 32'd0);
        end

        // Long RIGHT hold, then switch to UP.
        drive(4'b0000, 4'd1, 1'b0, 1'b1, 8'd0, 8'd0);
        cycle();
        xe = 8'd0;
        ye = 8'd0;
        drive(4'b1000, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int k = 0; k < 30; k++) begin
            cycle();
            m = exp_move(k);
            if (m) xe = xe + 8'd1;
            chk($sformatf("hold_r%0d_x", k), 32'(x_pos), 32'(xe));
            chk($sformatf("hold_r%0d_moved", k), 32'(moved), 32'(m));
        end
        chk("hold_r_final_x", 32'(x_pos), 32'(xe));
        drive(4'b0001, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int j = 0; j <= RD; j++) begin
            cycle();
            m = exp_move(j);
            if (m) ye = ye + 8'd1;
            chk($sformatf("hold_u%0d_y", j), 32'(y_pos), 32'(ye));
            chk($sformatf("hold_u%0d_x", j), 32'(x_pos), 32'(xe));
            chk($sformatf("hold_u%0d_moved", j), 32'(moved), 32'(m));
        end
        drive(4'b0000, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        cycle();

        // Diagonal hold.
        drive(4'b0000, 4'd1, 1'b0, 1'b1, 8'd0, 8'd0);
        cycle();
        xe = 8'd0;
        ye = 8'd0;
        drive(4'b1001, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            m = exp_move(k);
            if (m) begin
                xe = xe + 8'd1;
                ye = ye + 8'd1;
            end
            chk($sformatf("diag%0d_x", k), 32'(x_pos), 32'(xe));
            chk($sformatf("diag%0d_y", k), 32'(y_pos), 32'(ye));
        end

        // Load while RIGHT is held, then the hold resumes as a fresh press.
        drive(4'b1000, 4'd1, 1'b1, 1'b1, 8'd200, 8'd50);
        cycle();
        chk("hold_load_x", 32'(x_pos), 32'd159);
        chk("hold_load_y", 32'(y_pos), 32'd50);
        chk("hold_load_moved", 32'(moved), 32'd1);
        xe = 8'd159;
        drive(4'b1000, 4'd1, 1'b1, 1'b0, 8'd0, 8'd0);
        for (int k = 0; k < 2; k++) begin
            cycle();
            m = exp_move(k);
            if (m) xe = inc_wrap(xe, 8'd159);
            chk($sformatf("after_load%0d_x", k), 32'(x_pos), 32'(xe));
            chk($sformatf("after_load%0d_moved", k), 32'(moved), 32'(m));
        end

        // Asynchronous reset in the middle of a hold.
        cycle();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_x", 32'(x_pos), 32'd10);
        chk("async_rst_y", 32'(y_pos), 32'd20);
        chk("async_rst_moved", 32'(moved), 32'd0);
        drive(4'b0000, 4'd1, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("post_rst_x", 32'(x_pos), 32'd10);
        chk("post_rst_edge", 32'(at_edge), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pos_tracker.md
# pos_tracker

Parametrised X/Y position tracker for the on-screen cursor/sprite logic, the next generation of the 8-bit wrap-only tracker. It adds configurable grid bounds, programmable step size, a wrap or clamp edge mode, simultaneous X/Y (diagonal) moves, a synchronous position load, and an optional compiled-in auto-repeat timer so held buttons move at a controlled rate. It sits between the debounced button decoder and the renderer and collision logic.

## Interface
- WIDTH, 8: coordinate width in bits.
- X_MAX, 255: largest legal X; legal range is 0..X_MAX, and X_MAX must be at most 2^WIDTH-1.
- Y_MAX, 255: largest legal Y; same rule as X_MAX.
- X_INIT, 0 / Y_INIT, 0: reset position; must lie within bounds.
- STEP_W, 4: width of the step input.
- REPEAT_DELAY, 16: cycles from first move to first repeat; must be ≥1. Used only with auto-repeat.
- REPEAT_RATE, 4: cycles between repeats; must be ≥1. Used only with auto-repeat.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- dir_rldu  in  4  direction request: bit 3 RIGHT, bit 2 LEFT, bit 1 DOWN, bit 0 UP.
- step  in  STEP_W  move distance per tick; 0 means no movement. Must not exceed min(X_MAX, Y_MAX)+1.
- wrap_en  in  1  edge mode: 1 = wrap, 0 = clamp. Sampled every cycle.
- load_valid  in  1  load request for load_x/load_y.
- load_x, load_y  in  WIDTH  load target.
- x_pos, y_pos  out  WIDTH  current position, registered.
- moved  out  1  one-cycle pulse, registered: x_pos or y_pos changed on this edge.
- at_edge  out  4  {x==X_MAX, x==0, y==0, y==Y_MAX}, decoded from the registers.

## Operation
- Effective direction per axis:
  - X: +1 if only RIGHT is set, −1 if only LEFT is set, none if both or neither.
  - Y: +1 if only UP is set, −1 if only DOWN is set, none if both or neither.
  - X and Y move independently in the same tick, so diagonal moves are allowed. (0,0) is bottom-left.
- Arithmetic is done in WIDTH+1 bits.
  - Wrap, increment: if p+step > MAX, result is p+step−(MAX+1).
  - Wrap, decrement: if step > p, result is p+(MAX+1)−step.
  - Clamp: saturate at MAX or 0.
  - Clamp at a bound with further motion into it: position holds and moved stays 0.
- Load has priority over movement.
  - On a load_valid cycle, each coordinate is set to min(load, MAX) and the direction input is ignored.
  - The auto-repeat FSM returns to IDLE.
  - moved=1 only if the loaded value differs from the current value.
- A tick gates movement. Without auto-repeat, tick = effective direction non-zero, every cycle.
- Auto-repeat FSM (IDLE, DELAY, REPEAT), with cnt as a cycle counter:
  - IDLE: non-zero effective direction → tick, go to DELAY, cnt=0.
  - DELAY: when cnt==REPEAT_DELAY−1 → tick, go to REPEAT, cnt=0; otherwise cnt+1.
  - REPEAT: when cnt==REPEAT_RATE−1 → tick, cnt=0; otherwise cnt+1.
  - Effective direction zero in any state → go to IDLE, no tick.
  - Effective direction changes to a different non-zero value in DELAY or REPEAT → treated as a new press: tick, go to DELAY, cnt=0.

## Timing
- Reset values: x_pos=X_INIT, y_pos=Y_INIT, moved=0, FSM=IDLE, cnt=0. at_edge follows the reset position.
- Latency: inputs are sampled on edge N; the new position and moved are visible after edge N.
- Reset asserted mid-repeat clears state immediately. The first move after release needs a fresh press edge in IDLE, then follows the normal rules.
- wrap_en or step changing mid-hold takes effect on the next tick; the FSM is not disturbed.

## Configuration
- POS_TRACKER_AUTOREPEAT_EN defined: the FSM and cnt are built, and REPEAT_DELAY/REPEAT_RATE apply.
- Undefined: no FSM and no counter; movement happens every cycle a direction is held, and the repeat parameters are ignored.

## Structure
- Package pos_pkg holds:
  - direction bit index constants (DIR_RIGHT=3, DIR_LEFT=2, DIR_DOWN=1, DIR_UP=0);
  - the FSM state typedef (IDLE, DELAY, REPEAT);
  - the at_edge bit index constants.
- Sub-module pos_axis, instantiated twice (X and Y):
  - parameters WIDTH and MAX;
  - inputs: coordinate, signed direction, step, wrap_en, load;
  - outputs: next coordinate and changed flag.
- The FSM, load priority and output registers live in the top.

## Test plan
All cases use WIDTH=8, X_MAX=159, Y_MAX=119.
- Reset with X_INIT=10, Y_INIT=20 → x=10, y=20, moved=0, at_edge=0000. Asserting rst mid-hold returns x=10, y=20 asynchronously.
- Wrap mode, x=158, step=3, RIGHT for 1 tick → x=1. y=0, DOWN, step=1 → y=119.
- Clamp mode, x=158, step=3, RIGHT → x=159, at_edge[3]=1. A further tick gives x=159, moved=0.
- RIGHT+UP held with step=1 (macro undefined) → x and y both +1 per cycle. RIGHT+LEFT → x unchanged, moved=0.
- Macro defined, DELAY=16, RATE=4, RIGHT held 30 cycles from x=0 → moves on cycles 0, 16, 20, 24, 28, giving x=5. Switching to UP at cycle 30 → immediate y+1 and a fresh 16-cycle delay.
- load_valid with load_x=200, load_y=50 while RIGHT is held → x=159, y=50, moved=1, FSM back to IDLE. The next RIGHT tick occurs immediately after load_valid drops.
